// File: rtl/alu_pkg.sv
// Shared ALU command codes, MIPS opcode/funct constants and the instruction decoder
// used by the ID/EX issue stage.
package alu_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;

   localparam logic [2:0] CMD_ADD  = 3'd0;
   localparam logic [2:0] CMD_SUB  = 3'd1;
   localparam logic [2:0] CMD_XOR  = 3'd2;
   localparam logic [2:0] CMD_SLT  = 3'd3;
   localparam logic [2:0] CMD_AND  = 3'd4;
   localparam logic [2:0] CMD_NAND = 3'd5;
   localparam logic [2:0] CMD_NOR  = 3'd6;
   localparam logic [2:0] CMD_OR   = 3'd7;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;

   typedef struct packed {
      logic       legal;
      logic [2:0] cmd;
      logic       use_imm;
      logic       zext;
      logic       rt_used;
      logic       dest_rt;
      logic       reg_write;
      logic       is_load;
      logic       is_store;
   } dec_t;

   // reg_write here is before the destination-zero guard applied by the stage.
   function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
      dec_t d;
      d = '0;
      d.legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            d.rt_used   = 1'b1;
            d.reg_write = 1'b1;
            case (funct)
               F_ADD, F_ADDU: d.cmd = CMD_ADD;
               F_SUB, F_SUBU: d.cmd = CMD_SUB;
               F_AND:         d.cmd = CMD_AND;
               F_OR:          d.cmd = CMD_OR;
               F_XOR:         d.cmd = CMD_XOR;
               F_NOR:         d.cmd = CMD_NOR;
               F_SLT:         d.cmd = CMD_SLT;
               default:       d.legal = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            d.cmd = CMD_ADD; d.use_imm = 1'b1; d.dest_rt = 1'b1; d.reg_write = 1'b1;
         end
         OP_SLTI: begin
            d.cmd = CMD_SLT; d.use_imm = 1'b1; d.dest_rt = 1'b1; d.reg_write = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            d.cmd = (opcode == OP_ANDI) ? CMD_AND : (opcode == OP_ORI) ? CMD_OR : CMD_XOR;
            d.use_imm = 1'b1; d.zext = 1'b1; d.dest_rt = 1'b1; d.reg_write = 1'b1;
         end
         OP_LW: begin
            d.cmd = CMD_ADD; d.use_imm = 1'b1; d.dest_rt = 1'b1; d.reg_write = 1'b1;
            d.is_load = 1'b1;
         end
         OP_SW: begin
            d.cmd = CMD_ADD; d.use_imm = 1'b1; d.dest_rt = 1'b1; d.rt_used = 1'b1;
            d.is_store = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            d.cmd = CMD_SUB; d.dest_rt = 1'b1; d.rt_used = 1'b1;
         end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Per-source operand forwarding select: ALU result, then MEM write-back, then register file.
// Combinational; index 0 always yields zero.
module alu_fwd_mux #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_fwd,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = rf_data;
      if (src == '0)
         data = '0;
      else if (ex_fwd && ex_dest == src)
         data = alu_result;
      else if (mem_reg_write && mem_rd == src)
         data = mem_data;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: decode, operand forwarding, load-use bubble; 1-cycle latency.
// Backpressure: stall_in holds the register and raises hazard_stall; flush always wins.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic [5:0]        id_funct,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              stall_in,
   input  logic              flush,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_operand_a,
   output logic [DATA_W-1:0] ex_operand_b,
   output logic [2:0]        ex_command,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_reg_write,
   output logic              ex_is_load,
   output logic              ex_is_store,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              ex_illegal
);

   dec_t              dec;
   logic [REG_AW-1:0] dest;
   logic              reg_write;
   logic              ex_fwd;
   logic              load_use;
   logic              is_slt;
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext, src_b;

   assign dec       = decode(id_opcode, id_funct);
   assign dest      = dec.dest_rt ? id_rt : id_rd;
   assign reg_write = dec.reg_write & (dest != '0);
   assign ex_fwd    = ex_valid & ex_reg_write & ~ex_is_load;
   assign imm_ext   = dec.zext ? {{(DATA_W-16){1'b0}}, id_imm} : {{(DATA_W-16){id_imm[15]}}, id_imm};
   assign src_b     = dec.use_imm ? imm_ext : rt_val;
   assign is_slt    = (dec.cmd == CMD_SLT);

   alu_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .src(id_rs), .rf_data(id_rs_data), .ex_fwd(ex_fwd), .ex_dest(ex_dest),
      .alu_result(alu_result), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .mem_data(mem_data), .data(rs_val)
   );

   alu_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .src(id_rt), .rf_data(id_rt_data), .ex_fwd(ex_fwd), .ex_dest(ex_dest),
      .alu_result(alu_result), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .mem_data(mem_data), .data(rt_val)
   );

   // The loaded value only exists after MEM, so a dependent instruction must wait one cycle.
   assign load_use = id_valid & ex_valid & ex_is_load & (ex_dest != '0) &
                     ((ex_dest == id_rs) | (dec.rt_used & (ex_dest == id_rt)));
   assign hazard_stall = stall_in | load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_operand_a  <= '0;
         ex_operand_b  <= '0;
         ex_command    <= CMD_ADD;
         ex_dest       <= '0;
         ex_reg_write  <= 1'b0;
         ex_is_load    <= 1'b0;
         ex_is_store   <= 1'b0;
         ex_store_data <= '0;
         ex_illegal    <= 1'b0;
      end else if (stall_in && !flush) begin
         ex_illegal <= 1'b0;
      end else if (!flush && !load_use && id_valid && dec.legal) begin
         ex_valid      <= 1'b1;
         // ALU computes operandB < operandA, so SLT swaps the sources.
         ex_operand_a  <= is_slt ? src_b : rs_val;
         ex_operand_b  <= is_slt ? rs_val : src_b;
         ex_command    <= dec.cmd;
         ex_dest       <= dest;
         ex_reg_write  <= reg_write;
         ex_is_load    <= dec.is_load;
         ex_is_store   <= dec.is_store;
         ex_store_data <= rt_val;
         ex_illegal    <= 1'b0;
      end else begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_is_store  <= 1'b0;
         ex_illegal   <= !flush && !load_use && id_valid && !dec.legal;
      end
   end

endmodule
